pipe_stage_reg: RTL

- Parametrised pipeline-stage register for inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a packed WIDTH-bit stage payload with a valid/ready handshake and a synchronous flush that inserts a bubble.
- SKID=1 adds a second entry so in_ready is registered, which breaks the combinational ready chain across stages.
- Provides occupancy and a saturating stall counter for performance debug.

---
 rtl/pipe_pkg.sv | 57 +++++
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, stage payload types and bubble constants
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        branch;
  } idex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic [20:0] rsvd;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_t;

  // All-zero payloads decode as a NOP with every control bit deasserted.
  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      PS_ONE:  occ = 2'd1;
      PS_TWO:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage latch with valid/ready, flush, optional skid slot
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 128,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               SKID       = 1,
  parameter int               CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_head;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept, emit;
  logic             s_load, s_clear;

  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = m_q;
  assign occupancy = occ_of(state_q);
  assign stall_cnt = stall_q;

  generate
    if (SKID != 0) begin : g_ready_reg
      assign in_ready = (state_q != PS_TWO);
    end else begin : g_ready_comb
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_load  = 1'b0;
    s_clear = 1'b0;
    case (state_q)
      PS_EMPTY: begin
        if (accept) begin
          m_d     = in_data;
          state_d = PS_ONE;
        end
      end
      PS_ONE: begin
        if (emit && accept) begin
          m_d = in_data;
        end else if (emit) begin
          m_d     = BUBBLE_VAL;
          state_d = PS_EMPTY;
        end else if (accept && (SKID != 0)) begin
          s_load  = 1'b1;
          state_d = PS_TWO;
        end
      end
      PS_TWO: begin
        if (emit) begin
          m_d     = s_head;
          s_clear = 1'b1;
          state_d = PS_ONE;
        end
      end
      default: begin
        m_d     = BUBBLE_VAL;
        s_clear = 1'b1;
        state_d = PS_EMPTY;
      end
    endcase
    // Flush wins: handshakes still complete at the ports but the payload is dropped.
    if (flush) begin
      state_d = PS_EMPTY;
      m_d     = BUBBLE_VAL;
      s_load  = 1'b0;
      s_clear = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= PS_EMPTY;
      m_q     <= BUBBLE_VAL;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      stall_q <= stall_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] s_q, s_d;

      always_comb begin
        s_d = s_q;
        if (s_clear) begin
          s_d = BUBBLE_VAL;
        end else if (s_load) begin
          s_d = in_data;
        end
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          s_q <= BUBBLE_VAL;
        end else begin
          s_q <= s_d;
        end
      end

      assign s_head = s_q;
    end else begin : g_no_skid
      logic unused_skid;
      assign unused_skid = s_load ^ s_clear;
      assign s_head      = BUBBLE_VAL;
    end
  endgenerate

endmodule
